// File: rtl/audio_seq_pkg.sv
// Shared definitions for the audio output sequencer: register map, bit
// positions and the playback state type.
// Optional build macro: AUDIO_SEQ_IRQ_EN (adds irq_enable and low-watermark
// fields to CONTROL).
package audio_seq_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_HOLD_BIT   = 2;
  localparam int CTRL_IRQ_EN_BIT = 3;
  localparam int CTRL_WM_LSB     = 8;

  localparam int STAT_LEVEL_MSB    = 8;
  localparam int STAT_UNDERRUN_BIT = 16;
  localparam int STAT_OVERFLOW_BIT = 17;
  localparam int STAT_STATE_LSB    = 24;

  // Writable CONTROL bits; flush is a pulse and never stored.
`ifdef AUDIO_SEQ_IRQ_EN
  localparam logic [15:0] CTRL_WRITE_MASK = 16'hFF0D;
`else
  localparam logic [15:0] CTRL_WRITE_MASK = 16'h0005;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/audio_seq_fifo.sv
// Sample FIFO: register array read first-word-fall-through, so head is
// valid whenever the FIFO is not empty. Flush wins over push and pop.
module audio_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        push_data,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && !flush && (!full || pop_ok);
  assign head    = mem[rd_ptr_reg];
  assign level   = count_reg;

  // Sample storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/audio_out_sequencer.sv
// Avalon-MM audio output sequencer: CPU pushes samples into a FIFO and one
// sample is released to out_port per divider tick while playing.
// Optional build macro: AUDIO_SEQ_IRQ_EN (FIFO low-watermark interrupt).
module audio_out_sequencer
  import audio_seq_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          PRIME_LEVEL = 4,
  parameter logic [15:0] DIV_RESET   = 16'd1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port,
  output logic        sample_strobe,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  seq_state_t  state_reg;
  logic [15:0] tick_cnt_reg;
  logic [31:0] out_reg;
  logic        strobe_reg;
  logic [15:0] ctrl_reg;
  logic [15:0] div_reg;
  logic        underrun_reg;
  logic        overflow_reg;

  logic          wr_en, wr_data, wr_ctrl, wr_div, wr_stat;
  logic          flush, enable, hold_last, tick, pop;
  logic          underrun_evt, overflow_evt;
  logic [31:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [8:0]    level_9;

  assign wr_en   = chipselect && !write_n;
  assign wr_data = wr_en && (address == ADDR_DATA);
  assign wr_ctrl = wr_en && (address == ADDR_CTRL);
  assign wr_div  = wr_en && (address == ADDR_DIV);
  assign wr_stat = wr_en && (address == ADDR_STAT);

  assign flush     = wr_ctrl && writedata[CTRL_FLUSH_BIT];
  assign enable    = ctrl_reg[CTRL_ENABLE_BIT];
  assign hold_last = ctrl_reg[CTRL_HOLD_BIT];
  assign tick      = (state_reg == RUN) && enable && (tick_cnt_reg == '0);
  assign pop       = tick && !fifo_empty;
  // A push arriving with an empty-FIFO tick lands after the tick, not through it.
  assign underrun_evt = tick && fifo_empty;
  assign overflow_evt = wr_data && !flush && fifo_full && !pop;
  assign level_9      = 9'(fifo_level);

  audio_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_data),
    .pop       (pop),
    .flush     (flush),
    .push_data (writedata),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Playback FSM with tick counter, sample output and strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= DIV_RESET;
      out_reg      <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= tick;
      if (pop)                            out_reg <= fifo_head;
      else if (underrun_evt && !hold_last) out_reg <= '0;
      if (!enable) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: state_reg <= PRIME;
          PRIME: begin
            if (fifo_level >= PRIME_LVL) begin
              state_reg    <= RUN;
              tick_cnt_reg <= div_reg;
            end
          end
          RUN: begin
            tick_cnt_reg <= (tick_cnt_reg == '0) ? div_reg : tick_cnt_reg - 16'd1;
            if (flush || underrun_evt) state_reg <= PRIME;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // CONTROL and DIVIDER registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg <= '0;
      div_reg  <= DIV_RESET;
    end else begin
      if (wr_ctrl) ctrl_reg <= writedata[15:0] & CTRL_WRITE_MASK;
      if (wr_div)  div_reg  <= writedata[15:0];
    end
  end

  // Sticky status flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (underrun_evt)                                    underrun_reg <= 1'b1;
      else if (wr_stat && writedata[STAT_UNDERRUN_BIT])    underrun_reg <= 1'b0;
      if (overflow_evt)                                    overflow_reg <= 1'b1;
      else if (wr_stat && writedata[STAT_OVERFLOW_BIT])    overflow_reg <= 1'b0;
    end
  end

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = out_reg;
      ADDR_CTRL: readdata = {16'h0000, ctrl_reg};
      ADDR_DIV:  readdata = {16'h0000, div_reg};
      ADDR_STAT: begin
        readdata[STAT_LEVEL_MSB:0]      = level_9;
        readdata[STAT_UNDERRUN_BIT]     = underrun_reg;
        readdata[STAT_OVERFLOW_BIT]     = overflow_reg;
        readdata[STAT_STATE_LSB +: 2]   = state_reg;
      end
      default: readdata = '0;
    endcase
  end

  assign out_port      = out_reg;
  assign sample_strobe = strobe_reg;

`ifdef AUDIO_SEQ_IRQ_EN
  logic irq_reg;

  // Low-watermark interrupt, registered from current level and settings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= ctrl_reg[CTRL_IRQ_EN_BIT] && (state_reg != IDLE) &&
                          (level_9 <= {1'b0, ctrl_reg[CTRL_WM_LSB +: 8]});
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

endmodule
